// File: rtl/layer0_input_packer.sv
// layer0_input_packer: quantizes signed samples and packs them into double-buffered frames for layer 0
module layer0_input_packer #(
    parameter int NUM_FEATURES = 3,
    parameter int SAMPLE_W     = 16,
    parameter int IN_BITS      = 2,
    parameter int SHIFT        = 12,
    parameter int ERR_W        = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [SAMPLE_W-1:0]              s_data,
    input  logic                             s_last,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [NUM_FEATURES*IN_BITS-1:0]  m_data,
    output logic                             err_pulse,
    output logic [ERR_W-1:0]                 err_count
);
    localparam int W = NUM_FEATURES * IN_BITS;
    localparam int IW = NUM_FEATURES > 1 ? $clog2(NUM_FEATURES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_FEATURES - 1);
    localparam logic [1:0] ASSEMBLE = 2'd0;
    localparam logic [1:0] FULL     = 2'd1;
    localparam logic [1:0] RESYNC   = 2'd2;
    localparam logic signed [SAMPLE_W:0] OFS  = (SAMPLE_W + 1)'(2 ** (IN_BITS - 1));
    localparam logic signed [SAMPLE_W:0] QMAX = (SAMPLE_W + 1)'(2 ** IN_BITS - 1);

    logic [1:0]               st;
    logic [IW-1:0]            idx;
    logic [W-1:0]             asm_buf;
    logic [W-1:0]             nxt_buf;
    logic                     resync;
    logic                     acc;
    logic                     out_free;
    logic                     err;
    logic signed [SAMPLE_W:0] ext;
    logic signed [SAMPLE_W:0] sum;
    logic [IN_BITS-1:0]       q;

    assign s_ready  = !rst && st != FULL;
    assign acc      = s_valid && s_ready;
    assign out_free = !m_valid || m_ready;
    assign err      = acc && st == ASSEMBLE && (idx == LAST ? !s_last : s_last);

    // Quantize the incoming sample and form the assembly word with it placed in slot idx
    always_comb begin
        ext = {s_data[SAMPLE_W-1], s_data};
        sum = (ext >>> SHIFT) + OFS;
        q = sum < 0 ? '0 : sum > QMAX ? '1 : sum[IN_BITS-1:0];
        nxt_buf = asm_buf;
        nxt_buf[int'(idx)*IN_BITS +: IN_BITS] = q;
    end

    // Frame assembly, hold buffer, output register and error accounting
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= ASSEMBLE;
            idx       <= '0;
            asm_buf   <= '0;
            resync    <= 1'b0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= err;
            if (err && err_count != '1) err_count <= err_count + 1'b1;
            if (m_ready) m_valid <= 1'b0;
            if (st == ASSEMBLE && acc) begin
                if (idx != LAST) begin
                    idx     <= s_last ? '0 : idx + 1'b1;
                    asm_buf <= nxt_buf;
                end else begin
                    idx <= '0;
                    if (out_free) begin
                        m_data  <= nxt_buf;
                        m_valid <= 1'b1;
                        st      <= s_last ? ASSEMBLE : RESYNC;
                    end else begin
                        asm_buf <= nxt_buf;
                        st      <= FULL;
                        resync  <= !s_last;
                    end
                end
            end else if (st == FULL && m_ready) begin
                m_data  <= asm_buf;
                m_valid <= 1'b1;
                st      <= resync ? RESYNC : ASSEMBLE;
                resync  <= 1'b0;
            end else if (st == RESYNC && acc && s_last) begin
                st <= ASSEMBLE;
            end
        end
    end
endmodule

// File: tb/tb_layer0_input_packer.sv
// tb_layer0_input_packer: directed stimulus with a frame scoreboard for layer0_input_packer
module tb_layer0_input_packer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [5:0]  m_data;
    logic        err_pulse;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_err = 0;
    logic [5:0] exp_q[$];

    layer0_input_packer dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endfunction

    // Monitor: every output handshake is checked against the oldest expected frame
    initial forever begin
        @(negedge clk);
        #2;
        if (!rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_frame: got %0h required none", m_data);
            end else begin
                chk("frame", {26'd0, m_data}, {26'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    task automatic send(input logic [15:0] d, input logic l, output int w);
        bit done;
        @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        w = 0;
        done = 0;
        while (!done) begin
            #1;
            if (s_ready) done = 1;
            @(posedge clk);
            if (!done) begin
                w++;
                if (w > 50) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL send_timeout: got stalled required accept");
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic idle();
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    initial begin
        int w;
        int wc;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_err_count", err_count, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_s_ready", s_ready, 1);

        // quantize and pack: codes 2,3,0
        exp_q.push_back(6'b001110);
        send(16'h0000, 0, w);
        send(16'h7FFF, 0, w);
        send(16'h8000, 1, w);
        idle();
        #1;
        chk("latency_m_valid", m_valid, 1);
        chk("pack_m_data", m_data, 6'b001110);
        @(negedge clk);
        #1;
        chk("consumed_m_valid", m_valid, 0);

        // continuous streaming
        exp_q.push_back(6'b010101);
        exp_q.push_back(6'b111111);
        for (int i = 0; i < 6; i++) begin
            send(i < 3 ? 16'hF000 : 16'h1000, i == 2 || i == 5, w);
            chk("stream_no_stall", w, 0);
        end
        idle();
        repeat (2) @(negedge clk);

        // backpressure
        m_ready = 1'b0;
        exp_q.push_back(6'b101010);
        exp_q.push_back(6'b111111);
        exp_q.push_back(6'b010101);
        for (int i = 0; i < 3; i++) send(16'h0000, i == 2, w);
        for (int i = 0; i < 3; i++) send(16'h1000, i == 2, w);
        @(negedge clk);
        #1;
        chk("full_s_ready", s_ready, 0);
        chk("full_m_valid", m_valid, 1);
        chk("full_m_data", m_data, 6'b101010);
        fork
            begin
                send(16'hF000, 0, wc);
                chk("third_frame_stalled", wc > 0, 1);
                send(16'hF000, 0, wc);
                send(16'hF000, 1, wc);
            end
            begin
                repeat (4) @(negedge clk);
                #1;
                chk("held_m_data", m_data, 6'b101010);
                chk("held_s_ready", s_ready, 0);
                m_ready = 1'b1;
            end
        join
        idle();
        repeat (3) @(negedge clk);
        #1;
        chk("drained_s_ready", s_ready, 1);

        // early s_last
        send(16'h0000, 1, w);
        idle();
        #1;
        chk("early_err_pulse", err_pulse, 1);
        chk("early_no_valid", m_valid, 0);
        @(negedge clk);
        #1;
        chk("early_pulse_clear", err_pulse, 0);
        chk("early_err_count", err_count, 1);
        exp_q.push_back(6'b001110);
        send(16'h0000, 0, w);
        send(16'h7FFF, 0, w);
        send(16'h8000, 1, w);
        idle();
        repeat (2) @(negedge clk);

        // missing s_last, resync, then a good frame
        exp_q.push_back(6'b111111);
        exp_q.push_back(6'b000000);
        for (int i = 0; i < 3; i++) send(16'h7FFF, 0, w);
        send(16'h1234, 0, w);
        send(16'h1234, 1, w);
        for (int i = 0; i < 3; i++) send(16'h8000, i == 2, w);
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("missing_last_err_count", err_count, 2);

        // reset mid-frame
        send(16'h7FFF, 0, w);
        send(16'h7FFF, 0, w);
        @(negedge clk);
        s_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_s_ready", s_ready, 0);
        @(negedge clk);
        #1;
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_m_data", m_data, 0);
        chk("midrst_err_count", err_count, 0);
        chk("midrst_err_pulse", err_pulse, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_release_s_ready", s_ready, 1);
        exp_q.push_back(6'b001110);
        send(16'h0000, 0, w);
        send(16'h7FFF, 0, w);
        send(16'h8000, 1, w);
        idle();
        repeat (2) @(negedge clk);

        // reset while FULL
        m_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(16'h7FFF, i == 2 || i == 5, w);
        idle();
        #1;
        chk("pre_rst_full", s_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("fullrst_m_valid", m_valid, 0);
        chk("fullrst_m_data", m_data, 0);
        @(negedge clk);
        rst = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("fullrst_s_ready", s_ready, 1);
        exp_q.push_back(6'b010101);
        for (int i = 0; i < 3; i++) send(16'hF000, i == 2, w);
        idle();
        repeat (2) @(negedge clk);

        // error counter saturation
        for (int i = 0; i < 255; i++) send(16'h0000, 1, w);
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("sat_at_255", err_count, 255);
        for (int i = 0; i < 45; i++) send(16'h0000, 1, w);
        idle();
        repeat (2) @(negedge clk);
        #1;
        chk("sat_after_300", err_count, 255);

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
